seq_ripple_subtractor: RTL and testbench



---
 rtl/seq_ripple_subtractor_if.sv | 40 ++++
 rtl/seq_ripple_subtractor.sv | 145 ++++++++++++++
 tb/tb_seq_ripple_subtractor.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/seq_ripple_subtractor_if.sv
// Valid/ready bundle for seq_ripple_subtractor: operand channel in, result channel out.
// The slave modport is the subtractor's view and the master modport is the surrounding logic's view.
// With SEQ_SUB_FLAGS_EN defined, the result channel also carries the zero and ovf flags.
interface seq_ripple_subtractor_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         bout;
`ifdef SEQ_SUB_FLAGS_EN
    logic         zero;
    logic         ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero, ovf
    );
`else
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
`endif
endinterface

// File: rtl/seq_ripple_subtractor.sv
// seq_ripple_subtractor: multi-cycle unsigned subtractor, diff = a - b - bin mod 2^N.
// It handles CHUNK bits per clock and passes the borrow between chunks through a register,
// so one operation takes M = N/CHUNK cycles in RUN. Only one operation is in flight at a time.
// Optional feature macro SEQ_SUB_FLAGS_EN adds the registered zero and signed-overflow flags.
module seq_ripple_subtractor #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_ripple_subtractor_if.slave bus
);
    localparam int M  = N / CHUNK;
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;
    logic [N-1:0]   diff_reg;
    logic           borrow;
    logic           bout_reg;
    logic [IW-1:0]  idx;
    logic           in_ready_c;
    logic           out_valid_c;
    logic           accept;
    logic           last_chunk;
    logic [CHUNK:0] chunk_res;
    logic           chunk_borrow;
`ifdef SEQ_SUB_FLAGS_EN
    logic           zero_acc;
    logic           zero_reg;
    logic           ovf_reg;
    logic           chunk_zero;
`endif

    assign accept     = bus.in_valid & in_ready_c;
    assign last_chunk = (idx == IW'(M - 1));

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs, decoded from the current state only
    always_comb begin
        next_state  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // One chunk of subtraction; the extra top bit of the CHUNK+1 bit result is the borrow out
    always_comb begin
        chunk_res = {1'b0, a_reg[idx*CHUNK +: CHUNK]}
                  - {1'b0, b_reg[idx*CHUNK +: CHUNK]}
                  - {{CHUNK{1'b0}}, borrow};
        chunk_borrow = chunk_res[CHUNK];
    end

`ifdef SEQ_SUB_FLAGS_EN
    assign chunk_zero = (chunk_res[CHUNK-1:0] == '0);
`endif

    // Operand capture on acceptance, then chunk-by-chunk result build-up while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            diff_reg <= '0;
            borrow   <= 1'b0;
            bout_reg <= 1'b0;
            idx      <= '0;
`ifdef SEQ_SUB_FLAGS_EN
            zero_acc <= 1'b0;
            zero_reg <= 1'b0;
            ovf_reg  <= 1'b0;
`endif
        end else begin
            if (state == IDLE && accept) begin
                a_reg    <= bus.a;
                b_reg    <= bus.b;
                borrow   <= bus.bin;
                idx      <= '0;
`ifdef SEQ_SUB_FLAGS_EN
                zero_acc <= 1'b1;
`endif
            end else if (state == RUN) begin
                diff_reg[idx*CHUNK +: CHUNK] <= chunk_res[CHUNK-1:0];
                borrow <= chunk_borrow;
                idx    <= last_chunk ? '0 : idx + IW'(1);
`ifdef SEQ_SUB_FLAGS_EN
                zero_acc <= zero_acc & chunk_zero;
`endif
                if (last_chunk) begin
                    bout_reg <= chunk_borrow;
`ifdef SEQ_SUB_FLAGS_EN
                    zero_reg <= zero_acc & chunk_zero;
                    ovf_reg  <= (a_reg[N-1] != b_reg[N-1]) &
                                (chunk_res[CHUNK-1] != a_reg[N-1]);
`endif
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.diff      = diff_reg;
    assign bus.bout      = bout_reg;
`ifdef SEQ_SUB_FLAGS_EN
    assign bus.zero      = zero_reg;
    assign bus.ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_seq_ripple_subtractor.sv
// Directed testbench for seq_ripple_subtractor (N=32, CHUNK=8).
// Expected results below are hand-computed; flag checks appear only when SEQ_SUB_FLAGS_EN is defined.
module tb_seq_ripple_subtractor;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    seq_ripple_subtractor_if #(.N(32)) bus_if ();

    seq_ripple_subtractor #(
        .N     (32),
        .CHUNK (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Safety net so a stuck design can never hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one operation, wait for acceptance, then wait for the result and check it.
    // The result is left pending (out_ready low) so the caller can inspect flags or stall.
    task automatic applyStimulus(input string tag, input logic [31:0] av, input logic [31:0] bv,
                                 input logic binv, input logic [31:0] exp_diff,
                                 input logic exp_bout);
        int n;
        bus_if.a        = av;
        bus_if.b        = bv;
        bus_if.bin      = binv;
        bus_if.in_valid = 1'b1;
        n = 0;
        while (bus_if.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_in_ready"}, 64'(bus_if.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        bus_if.a        = ~av;
        bus_if.b        = ~bv;
        bus_if.bin      = ~binv;
        checkOutput({tag, "_busy"}, 64'(bus_if.in_ready), 64'd0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus_if.out_valid !== 1'b1 && n < 20);
        checkOutput({tag, "_latency"}, 64'(n), 64'd4);
        checkOutput({tag, "_out_valid"}, 64'(bus_if.out_valid), 64'd1);
        checkOutput({tag, "_diff"}, 64'(bus_if.diff), 64'(exp_diff));
        checkOutput({tag, "_bout"}, 64'(bus_if.bout), 64'(exp_bout));
    endtask

    // Accept the pending result and confirm the block is back to idle
    task automatic releaseResult(input string tag);
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        checkOutput({tag, "_released"}, 64'(bus_if.out_valid), 64'd0);
        checkOutput({tag, "_idle_ready"}, 64'(bus_if.in_ready), 64'd1);
    endtask

`ifdef SEQ_SUB_FLAGS_EN
    task automatic checkFlags(input string tag, input logic exp_zero, input logic exp_ovf);
        checkOutput({tag, "_zero"}, 64'(bus_if.zero), 64'(exp_zero));
        checkOutput({tag, "_ovf"}, 64'(bus_if.ovf), 64'(exp_ovf));
    endtask
`endif

    // Main directed sequence
    initial begin
        int seen;

        // Reset held with random inputs applied
        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.a         = $urandom;
        bus_if.b         = $urandom;
        bus_if.bin       = 1'b1;
        bus_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_diff", 64'(bus_if.diff), 64'd0);
        checkOutput("rst_bout", 64'(bus_if.bout), 64'd0);
        checkOutput("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        @(negedge clk);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        rst_n            = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
        checkOutput("rst_out_valid_after", 64'(bus_if.out_valid), 64'd0);

        // Basic subtraction without borrow
        applyStimulus("basic", 32'h0000000A, 32'h00000003, 1'b0, 32'h00000007, 1'b0);
`ifdef SEQ_SUB_FLAGS_EN
        checkFlags("basic", 1'b0, 1'b0);
`endif
        releaseResult("basic");

        // Borrow ripples through all four chunks
        applyStimulus("ripple", 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b1);
`ifdef SEQ_SUB_FLAGS_EN
        checkFlags("ripple", 1'b0, 1'b0);
`endif
        releaseResult("ripple");

        // Borrow crossing the chunk 0 / chunk 1 boundary, with borrow-in
        applyStimulus("boundary", 32'h00000100, 32'h00000001, 1'b1, 32'h000000FE, 1'b0);
`ifdef SEQ_SUB_FLAGS_EN
        checkFlags("boundary", 1'b0, 1'b0);
        releaseResult("boundary");
        applyStimulus("ovf", 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0);
        checkFlags("ovf", 1'b0, 1'b1);
        releaseResult("ovf");
        applyStimulus("zero", 32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0);
        checkFlags("zero", 1'b1, 1'b0);
        releaseResult("zero");
`else
        releaseResult("boundary");
`endif

        // Backpressure: result held while a new operation is offered
        applyStimulus("bp", 32'h00000010, 32'h00000001, 1'b0, 32'h0000000F, 1'b0);
        bus_if.a        = 32'h00000020;
        bus_if.b        = 32'h00000030;
        bus_if.bin      = 1'b0;
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_hold_valid", 64'(bus_if.out_valid), 64'd1);
            checkOutput("bp_hold_diff", 64'(bus_if.diff), 64'h0000000F);
            checkOutput("bp_hold_bout", 64'(bus_if.bout), 64'd0);
            checkOutput("bp_hold_in_ready", 64'(bus_if.in_ready), 64'd0);
        end
        releaseResult("bp");
        applyStimulus("bp_new", 32'h00000020, 32'h00000030, 1'b0, 32'hFFFFFFF0, 1'b1);
        releaseResult("bp_new");

        // Reset asserted while chunk 2 is being processed
        bus_if.a        = 32'h01020304;
        bus_if.b        = 32'h00000001;
        bus_if.bin      = 1'b0;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 64'(bus_if.out_valid), 64'd0);
        checkOutput("midrst_diff", 64'(bus_if.diff), 64'd0);
        checkOutput("midrst_bout", 64'(bus_if.bout), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.out_valid !== 1'b0) seen++;
        end
        checkOutput("midrst_no_result", 64'(seen), 64'd0);
        applyStimulus("post_rst", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1);
`ifdef SEQ_SUB_FLAGS_EN
        checkFlags("post_rst", 1'b0, 1'b0);
`endif
        releaseResult("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
